pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Parametrised hazard and forwarding controller for the in-order ARM pipeline; replaces the fixed 5-stage forwarding/flush logic with one generalised block.
- Keeps a per-stage scoreboard of in-flight destination registers and drives per-stage enables and flushes, the PC enable, and the ALU forwarding selects.
- Adds load-use stall, variable-latency data-memory wait with a watchdog, and saturating stall/flush performance counters.

Parameters:
NSTAGES, 5, pipeline depth; stage index 0=IF, 1=ID, 2=EX, 3=MEM, NSTAGES-1=WB; legal range 5..8 (extra stages are MEM sub-stages between 3 and NSTAGES-2).
REG_AW, 5, register address width.
ZERO_REG, 31, register index that never creates a hazard or a forward (XZR).
MEM_WAIT_MAX, 15, number of memory-wait cycles after which the watchdog fires.
CNT_W, 32, width of the performance counters.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  asynchronous, active-low reset.
id_valid  in  1  ID stage holds a real instruction.
id_rs1, id_rs2  in  REG_AW  ID source registers (ReadRegister1/2 after the Reg2Loc and link muxes).
id_rs1_used, id_rs2_used  in  1  source operand is actually read.
id_rd  in  REG_AW  ID destination register.
id_regwrite, id_memread  in  1  ID instruction writes the register file / is a load.
ex_branch_taken  in  1  branch resolved taken in EX this cycle.
mem_req  in  1  MEM-stage (index 3) access active.
mem_ready  in  1  data memory completes the access this cycle.
stage_en  out  NSTAGES  per-stage advance enable.
stage_flush  out  NSTAGES  per-stage bubble insert.
pc_en  out  1  PC update enable.
fwd_a, fwd_b  out  2  forwarding select for ALU A/B: 00 register file, 01 WB, 10 MEM.
stall_cnt, flush_cnt  out  CNT_W  saturating performance counters.
wait_timeout  out  1  sticky watchdog flag.

Behaviour:
- Scoreboard: one entry per stage 2..NSTAGES-1 holding {valid, rd, regwrite, memread, rs1, rs2, rs1_used, rs2_used}. Each entry shifts to the next stage when that stage's stage_en=1. A bubble writes valid=0.
- Hazard and forwarding outputs are combinational from the scoreboard and current inputs (0-cycle latency). Counters and wait_timeout are registered.
- A register matches only if it is valid, has regwrite=1, and rd!=ZERO_REG. "Matches" below means this test passes and rd equals the compared source.
- Reset, with inputs idle: all scoreboard entries invalid; stage_en all 1s; pc_en=1; stage_flush=0; fwd_a=fwd_b=00; counters=0; wait_timeout=0. Reset mid-stall or mid-wait aborts immediately. The first cycle after release behaves as idle.
- Condition priorities, highest first:
  1. MEM wait (mem_req & !mem_ready): stage_en[0..3]=0 and pc_en=0. Stages 4..NSTAGES-1 advance; the entry leaving stage 3 is a bubble (stage_flush[4]=1). ex_branch_taken is ignored; the source holds it until EX advances.
  2. Branch flush (ex_branch_taken, no wait): stage_flush[0]=stage_flush[1]=1. The EX entry is replaced by a bubble. pc_en=1 so the branch target loads. flush_cnt+1.
  3. Load-use (id_valid, EX entry matches a used ID source, EX memread=1): pc_en=0, stage_en[0]=stage_en[1]=0, stage_flush[2]=1. Lasts exactly one cycle; the following cycle is resolved by forwarding from MEM.
- A branch in the same cycle as a load-use overrides the stall; the younger ID instruction is flushed.
- Forwarding: computed for the EX entry's rs1 (fwd_a) and rs2 (fwd_b) when the corresponding used flag is 1.
  - 10 if stage 3 matches.
  - Else 01 if stage NSTAGES-1 matches.
  - Else 00.
  - Intermediate stages 4..NSTAGES-2 that match force a load-use style one-cycle stall instead of forwarding.
- stall_cnt increments once per cycle of load-use stall or MEM wait. Both counters saturate at all 1s.
- Watchdog: an internal counter counts consecutive wait cycles and clears when mem_ready=1. When it reaches MEM_WAIT_MAX, wait_timeout is set and stays 1 until reset. The pipeline keeps waiting.

Test Plan:
- Reset, then idle inputs -> stage_en=5'b11111, pc_en=1, fwd 00, counters 0.
- ADD X1 in EX, next-cycle SUB reads X1 -> EX→MEM shift; fwd_a=10; one cycle later fwd_a=01; no stall.
- LDUR X2, then ADD X3,X2,X4 in ID -> exactly one cycle pc_en=0, stage_flush[2]=1; next cycle fwd_b=10; stall_cnt=1.
- Load-use and ex_branch_taken in the same cycle -> stage_flush=5'b00111, pc_en=1, flush_cnt=1, stall_cnt unchanged.
- mem_req=1, mem_ready=0 for 16 cycles -> stage_en[3:0]=0 throughout; wait_timeout rises after 15 wait cycles and stays 1 after mem_ready; stall_cnt=16.
- Writes to X31 in EX/MEM/WB with dependent reader -> never stall, fwd stays 00. Assert rst mid-wait -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller for the in-order pipeline: scoreboard of in-flight
// writers (EX..WB), stage enables/flushes, PC enable, ALU forward selects, perf counters.
module pipe_hazard_ctrl #(
  parameter int NSTAGES      = 5,
  parameter int REG_AW       = 5,
  parameter int ZERO_REG     = 31,
  parameter int MEM_WAIT_MAX = 15,
  parameter int CNT_W        = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic [REG_AW-1:0]  id_rs1,
  input  logic [REG_AW-1:0]  id_rs2,
  input  logic               id_rs1_used,
  input  logic               id_rs2_used,
  input  logic [REG_AW-1:0]  id_rd,
  input  logic               id_regwrite,
  input  logic               id_memread,
  input  logic               ex_branch_taken,
  input  logic               mem_req,
  input  logic               mem_ready,
  output logic [NSTAGES-1:0] stage_en,
  output logic [NSTAGES-1:0] stage_flush,
  output logic               pc_en,
  output logic [1:0]         fwd_a,
  output logic [1:0]         fwd_b,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt,
  output logic               wait_timeout
);

  localparam int                WD_W   = $clog2(MEM_WAIT_MAX + 1);
  localparam logic [REG_AW-1:0] ZR     = REG_AW'(ZERO_REG);
  localparam logic [WD_W-1:0]   WD_MAX = WD_W'(MEM_WAIT_MAX);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              regwrite;
    logic              memread;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              rs1_used;
    logic              rs2_used;
  } sb_t;

  sb_t               sb_q [2:NSTAGES-1];
  sb_t               sb_d [2:NSTAGES-1];
  sb_t               id_entry;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;
  logic              wait_timeout_q, wait_timeout_d;

  logic              mem_wait, load_use, fwd_stall, stall_ev, flush_ev;
  logic [1:0]        op_used, op_hit, op_stall;
  logic [REG_AW-1:0] op_src [2];
  logic [1:0]        fwd_sel [2];

  function automatic logic writes_reg(input sb_t e, input logic [REG_AW-1:0] r);
    return e.valid && e.regwrite && (e.rd != ZR) && (e.rd == r);
  endfunction

  assign id_entry = '{valid: id_valid, rd: id_rd, regwrite: id_regwrite, memread: id_memread,
                      rs1: id_rs1, rs2: id_rs2, rs1_used: id_rs1_used, rs2_used: id_rs2_used};

  assign op_used   = {sb_q[2].rs2_used, sb_q[2].rs1_used};
  assign op_src[0] = sb_q[2].rs1;
  assign op_src[1] = sb_q[2].rs2;

  // Youngest matching producer wins; MEM sub-stages have no bypass path, so a hit there stalls EX.
  always_comb begin
    op_hit   = '0;
    op_stall = '0;
    for (int op = 0; op < 2; op++) begin
      fwd_sel[op] = 2'b00;
      if (op_used[op]) begin
        if (writes_reg(sb_q[3], op_src[op])) begin
          fwd_sel[op] = 2'b10;
          op_hit[op]  = 1'b1;
        end
        for (int s = 4; s <= NSTAGES - 2; s++) begin
          if (!op_hit[op] && writes_reg(sb_q[s], op_src[op])) begin
            op_stall[op] = 1'b1;
            op_hit[op]   = 1'b1;
          end
        end
        if (!op_hit[op] && writes_reg(sb_q[NSTAGES-1], op_src[op]))
          fwd_sel[op] = 2'b01;
      end
    end
  end

  assign fwd_a     = fwd_sel[0];
  assign fwd_b     = fwd_sel[1];
  assign fwd_stall = |op_stall;
  assign mem_wait  = mem_req & ~mem_ready;
  assign load_use  = id_valid && sb_q[2].memread &&
                     ((id_rs1_used && writes_reg(sb_q[2], id_rs1)) ||
                      (id_rs2_used && writes_reg(sb_q[2], id_rs2)));

  always_comb begin
    stage_en    = '1;
    stage_flush = '0;
    pc_en       = 1'b1;
    stall_ev    = 1'b0;
    flush_ev    = 1'b0;
    if (mem_wait) begin
      stage_en[3:0]  = '0;
      stage_flush[4] = 1'b1;
      pc_en          = 1'b0;
      stall_ev       = 1'b1;
    end else if (fwd_stall) begin
      stage_en[2:0]  = '0;
      stage_flush[3] = 1'b1;
      pc_en          = 1'b0;
      stall_ev       = 1'b1;
    end else if (ex_branch_taken) begin
      stage_flush[2:0] = 3'b111;
      flush_ev         = 1'b1;
    end else if (load_use) begin
      stage_en[1:0]  = '0;
      stage_flush[2] = 1'b1;
      pc_en          = 1'b0;
      stall_ev       = 1'b1;
    end
    // Held in reset, the control outputs show idle values regardless of inputs.
    if (!rst) begin
      stage_en    = '1;
      stage_flush = '0;
      pc_en       = 1'b1;
      stall_ev    = 1'b0;
      flush_ev    = 1'b0;
    end
  end

  always_comb begin
    sb_d[2] = sb_q[2];
    if (stage_en[2]) sb_d[2] = stage_flush[2] ? '0 : id_entry;
    for (int s = 3; s < NSTAGES; s++) begin
      sb_d[s] = sb_q[s];
      if (stage_en[s]) sb_d[s] = stage_flush[s] ? '0 : sb_q[s-1];
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_ev && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush_ev && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    wd_cnt_d = '0;
    if (mem_wait) wd_cnt_d = (wd_cnt_q == WD_MAX) ? wd_cnt_q : wd_cnt_q + WD_W'(1);
    wait_timeout_d = wait_timeout_q | (mem_wait && (wd_cnt_d == WD_MAX));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 2; s < NSTAGES; s++) sb_q[s] <= '0;
      stall_cnt_q    <= '0;
      flush_cnt_q    <= '0;
      wd_cnt_q       <= '0;
      wait_timeout_q <= 1'b0;
    end else begin
      for (int s = 2; s < NSTAGES; s++) sb_q[s] <= sb_d[s];
      stall_cnt_q    <= stall_cnt_d;
      flush_cnt_q    <= flush_cnt_d;
      wd_cnt_q       <= wd_cnt_d;
      wait_timeout_q <= wait_timeout_d;
    end
  end

  assign stall_cnt    = stall_cnt_q;
  assign flush_cnt    = flush_cnt_q;
  assign wait_timeout = wait_timeout_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: instruction-level pipeline model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_rs1_used, id_rs2_used, id_regwrite, id_memread;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       ex_branch_taken, mem_req, mem_ready;

  logic [4:0]  stage_en, stage_flush;
  logic        pc_en, wait_timeout;
  logic [1:0]  fwd_a, fwd_b;
  logic [31:0] stall_cnt, flush_cnt;

  logic [4:0]  en2, fl2;
  logic        pc2, wt2;
  logic [1:0]  fa2, fb2, sc2, fc2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .stage_en(stage_en), .stage_flush(stage_flush),
    .pc_en(pc_en), .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
    .wait_timeout(wait_timeout)
  );

  // Narrow-counter instance to reach counter saturation quickly.
  pipe_hazard_ctrl #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .stage_en(en2), .stage_flush(fl2),
    .pc_en(pc2), .fwd_a(fa2), .fwd_b(fb2), .stall_cnt(sc2), .flush_cnt(fc2),
    .wait_timeout(wt2)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model: instructions sitting in EX, MEM, WB ----------------
  typedef struct {
    bit v; int rd; bit rw; bit mr; int rs1; int rs2; bit u1; bit u2;
  } ins_t;

  ins_t   m [2:4];
  ins_t   bub;
  ins_t   idi;
  int     mode;
  longint e_stall, e_flush;
  int     run;
  bit     e_to;
  bit [4:0] xe, xf;
  bit     xpc;

  function automatic bit wr(input ins_t e, input int r);
    return e.v && e.rw && (e.rd != 31) && (e.rd == r);
  endfunction

  function automatic int fsel(input bit u, input int r, input ins_t mem, input ins_t wb);
    if (!u) return 0;
    if (wr(mem, r)) return 2;
    if (wr(wb, r)) return 1;
    return 0;
  endfunction

  function automatic longint sat3(input longint v);
    return (v > 3) ? 3 : v;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 2; k <= 4; k++) m[k] = bub;
      e_stall = 0; e_flush = 0; run = 0; e_to = 0; mode = 0;
      xe = 5'b11111; xf = 5'b00000; xpc = 1'b1;
    end else begin
      if (mem_req && !mem_ready) mode = 1;
      else if (ex_branch_taken) mode = 2;
      else if (id_valid && m[2].mr && ((id_rs1_used && wr(m[2], int'(id_rs1))) ||
                                       (id_rs2_used && wr(m[2], int'(id_rs2))))) mode = 3;
      else mode = 0;
      case (mode)
        1:       begin xe = 5'b10000; xf = 5'b10000; xpc = 1'b0; end
        2:       begin xe = 5'b11111; xf = 5'b00111; xpc = 1'b1; end
        3:       begin xe = 5'b11100; xf = 5'b00100; xpc = 1'b0; end
        default: begin xe = 5'b11111; xf = 5'b00000; xpc = 1'b1; end
      endcase
    end
    chk("stage_en", stage_en, xe);
    chk("stage_flush", stage_flush, xf);
    chk("pc_en", pc_en, xpc);
    chk("fwd_a", fwd_a, fsel(m[2].u1, m[2].rs1, m[3], m[4]));
    chk("fwd_b", fwd_b, fsel(m[2].u2, m[2].rs2, m[3], m[4]));
    chk("stall_cnt", stall_cnt, e_stall);
    chk("flush_cnt", flush_cnt, e_flush);
    chk("wait_timeout", wait_timeout, e_to);
    chk("stall_cnt_sat", sc2, sat3(e_stall));
    chk("flush_cnt_sat", fc2, sat3(e_flush));
  end

  always @(posedge clk) begin
    if (rst) begin
      idi = '{v: id_valid, rd: int'(id_rd), rw: id_regwrite, mr: id_memread,
              rs1: int'(id_rs1), rs2: int'(id_rs2), u1: id_rs1_used, u2: id_rs2_used};
      case (mode)
        1:       m[4] = bub;
        2, 3:    begin m[4] = m[3]; m[3] = m[2]; m[2] = bub; end
        default: begin m[4] = m[3]; m[3] = m[2]; m[2] = idi; end
      endcase
      if ((mode == 1 || mode == 3) && e_stall < 64'hFFFF_FFFF) e_stall++;
      if (mode == 2 && e_flush < 64'hFFFF_FFFF) e_flush++;
      if (mode == 1) begin
        run++;
        if (run >= 15) e_to = 1'b1;
      end else begin
        run = 0;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic set_id(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                        input int rd, input bit rw, input bit mr);
    id_valid = v; id_rs1 = 5'(rs1); id_rs1_used = u1; id_rs2 = 5'(rs2); id_rs2_used = u2;
    id_rd = 5'(rd); id_regwrite = rw; id_memread = mr;
  endtask

  task automatic idle_id();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    $display("txn t=%0t rst=%b id_v=%b rs1=%0d/%b rs2=%0d/%b rd=%0d rw=%b mr=%b br=%b mreq=%b mrdy=%b",
             $time, rst, id_valid, id_rs1, id_rs1_used, id_rs2, id_rs2_used, id_rd,
             id_regwrite, id_memread, ex_branch_taken, mem_req, mem_ready);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle_id();
    ex_branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    bub = '{default: 0};
    rst = 1'b0;
    idle_id();
    ex_branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    #2;
    chk("reset_stage_en", stage_en, 5'b11111);
    chk("reset_pc_en", pc_en, 1);
    chk("reset_flush", stage_flush, 0);
    chk("reset_stall_cnt", stall_cnt, 0);
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("idle_stage_en", stage_en, 5'b11111);
    chk("idle_fwd_a", fwd_a, 0);

    // ADD X1,X2,X3 then SUB X6,X1,X5 then ORR X7,X1,X8
    set_id(1, 2, 1, 3, 1, 1, 1, 0); tick();
    set_id(1, 1, 1, 5, 1, 6, 1, 0); #1;
    chk("alu_dep_no_stall", pc_en, 1);
    tick();
    set_id(1, 1, 1, 8, 1, 7, 1, 0); #1;
    chk("fwd_a_from_mem", fwd_a, 2'b10);
    chk("fwd_b_none", fwd_b, 2'b00);
    tick();
    idle_id(); #1;
    chk("fwd_a_from_wb", fwd_a, 2'b01);
    tick(); tick(); tick();

    // LDUR X2,[X9] then ADD X3,X4,X2
    do_reset();
    set_id(1, 9, 1, 0, 0, 2, 1, 1); tick();
    set_id(1, 4, 1, 2, 1, 3, 1, 0); #1;
    chk("luse_pc_en", pc_en, 0);
    chk("luse_flush", stage_flush, 5'b00100);
    chk("luse_en", stage_en, 5'b11100);
    tick();
    #1;
    chk("luse_one_cycle", pc_en, 1);
    chk("luse_stall_cnt", stall_cnt, 1);
    tick();
    idle_id(); tick(); tick(); tick();

    // load-use coinciding with a taken branch, then a plain branch
    do_reset();
    set_id(1, 9, 1, 0, 0, 5, 1, 1); tick();
    set_id(1, 5, 1, 6, 1, 10, 1, 0); ex_branch_taken = 1'b1; #1;
    chk("br_luse_flush", stage_flush, 5'b00111);
    chk("br_luse_pc_en", pc_en, 1);
    chk("br_luse_en", stage_en, 5'b11111);
    tick();
    ex_branch_taken = 1'b0; idle_id(); #1;
    chk("br_flush_cnt", flush_cnt, 1);
    chk("br_stall_unchanged", stall_cnt, 0);
    ex_branch_taken = 1'b1; #1;
    chk("br_only_flush", stage_flush, 5'b00111);
    tick();
    ex_branch_taken = 1'b0; #1;
    chk("br_flush_cnt2", flush_cnt, 2);
    tick();

    // 16-cycle memory wait with an ADD X8 parked in MEM
    do_reset();
    set_id(1, 2, 1, 3, 1, 8, 1, 0); tick();
    idle_id(); tick();
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      #1;
      chk("wait_en_low", stage_en[3:0], 0);
      chk("wait_watchdog", wait_timeout, (i >= 16) ? 1 : 0);
      tick();
    end
    mem_ready = 1'b1; #1;
    chk("wait_stall_cnt", stall_cnt, 16);
    chk("wait_timeout_kept", wait_timeout, 1);
    chk("wait_done_en", stage_en, 5'b11111);
    tick();
    mem_req = 1'b0; mem_ready = 1'b0; #1;
    chk("wait_timeout_sticky", wait_timeout, 1);
    tick();

    // reset asserted in the middle of a memory wait
    mem_req = 1'b1; tick(); tick(); tick();
    rst = 1'b0; #1;
    chk("arst_en", stage_en, 5'b11111);
    chk("arst_pc_en", pc_en, 1);
    chk("arst_flush", stage_flush, 0);
    chk("arst_stall_cnt", stall_cnt, 0);
    chk("arst_timeout", wait_timeout, 0);
    tick();
    mem_req = 1'b0; tick();
    rst = 1'b1;

    // X31 producers never cause hazards or forwards
    set_id(1, 9, 1, 0, 0, 31, 1, 1); tick();
    set_id(1, 31, 1, 31, 1, 12, 1, 0); #1;
    chk("xzr_no_stall", pc_en, 1);
    chk("xzr_no_flush", stage_flush, 0);
    tick();
    set_id(1, 31, 1, 31, 1, 13, 1, 0); #1;
    chk("xzr_fwd_a_mem", fwd_a, 0);
    chk("xzr_fwd_b_mem", fwd_b, 0);
    tick();
    idle_id(); #1;
    chk("xzr_fwd_a_wb", fwd_a, 0);
    chk("xzr_fwd_b_wb", fwd_b, 0);
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
